branch_predictor: RTL

//  Parametrised dynamic branch predictor for the 5-stage core. Replaces the static predict path.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_counter_table.sv | 47 ++++
 rtl/branch_predictor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Provides the 2-bit counter encoding, its reset value and the
// saturating step function used when a conditional branch resolves.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    // Saturating step: towards ST on taken, towards SNT on not-taken.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t result;
        result = ctr;
        case (ctr)
            SNT:     result = taken ? WNT : SNT;
            WNT:     result = taken ? WT  : SNT;
            WT:      result = taken ? ST  : WNT;
            ST:      result = taken ? ST  : WT;
            default: result = CTR_RESET;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating direction counters.
// One combinational read port for lookup, one write port for training.
// The write port either loads an absolute value (new allocation) or
// steps the addressed counter in place, so the trainer needs no read port.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_set,
    input  ctr_t             wr_ctr,
    input  logic             wr_taken
);

    ctr_t ctr_q [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            ctr_t ctr_reg;
            ctr_t ctr_next_val;

            assign ctr_next_val = wr_set ? wr_ctr : ctr_next(ctr_reg, wr_taken);

            // Per-entry counter: async clear, load or saturating step on write hit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ctr_reg <= CTR_RESET;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ctr_reg <= ctr_next_val;
                end
            end

            assign ctr_q[gi] = ctr_reg;
        end
    endgenerate

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit counter table.
// Lookup of fetch_pc is combinational; training from the MEM stage is
// registered and visible the cycle after update_valid (no bypass).
// Optional macro BP_GSHARE_EN: counter table indexed by idx ^ global history.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_is_branch,
    input  logic            update_is_jump,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_mispredict,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_LO + TAG_W - 1;

    // BTB storage; tag/target/jmp are qualified by valid so they need no reset.
    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [XLEN-1:0]    target_mem [ENTRIES];
    logic               jmp_mem    [ENTRIES];
    logic [31:0]        stat_reg;

    // Field extraction
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             unused_pc_bits;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[TAG_HI:TAG_LO];
    assign upd_idx   = update_pc[IDX_W+1:2];
    assign upd_tag   = update_pc[TAG_HI:TAG_LO];

    // Byte-offset bits and bits above the tag never take part in indexing.
    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0],
                              fetch_pc >> (TAG_HI + 1), update_pc >> (TAG_HI + 1)};

    // Update classification; a jump flag wins when both type flags are set.
    logic upd_accept;
    logic upd_jump;
    logic upd_branch;
    logic upd_hit;
    logic btb_alloc;
    logic tgt_write;

    assign upd_accept = update_valid & (update_is_branch | update_is_jump);
    assign upd_jump   = upd_accept & update_is_jump;
    assign upd_branch = upd_accept & ~update_is_jump;
    assign upd_hit    = valid_reg[upd_idx] & (tag_mem[upd_idx] == upd_tag);
    assign btb_alloc  = upd_jump | (upd_branch & ~upd_hit & update_taken);
    assign tgt_write  = upd_jump | (upd_branch & update_taken);

    // Counter-table indexing, optionally hashed with global history.
    logic [IDX_W-1:0] look_cidx;
    logic [IDX_W-1:0] upd_cidx;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_reg;

    // Non-speculative global history: shift in each resolved conditional branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_reg <= '0;
        end else if (upd_branch) begin
            ghr_reg <= (ghr_reg << 1) | IDX_W'(update_taken);
        end
    end

    assign look_cidx = fetch_idx ^ ghr_reg;
    assign upd_cidx  = upd_idx ^ ghr_reg;
`else
    assign look_cidx = fetch_idx;
    assign upd_cidx  = upd_idx;
`endif

    // Direction counters
    ctr_t look_ctr;
    logic ctr_wr_en;
    ctr_t ctr_wr_val;

    assign ctr_wr_en  = btb_alloc | (upd_branch & upd_hit);
    assign ctr_wr_val = upd_jump ? ST : WT;

    bp_counter_table #(
        .ENTRIES (ENTRIES)
    ) u_ctr_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (look_cidx),
        .rd_ctr   (look_ctr),
        .wr_en    (ctr_wr_en),
        .wr_idx   (upd_cidx),
        .wr_set   (btb_alloc),
        .wr_ctr   (ctr_wr_val),
        .wr_taken (update_taken)
    );

    // Valid bits: cleared asynchronously, set on any allocation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
        end else if (btb_alloc) begin
            valid_reg[upd_idx] <= 1'b1;
        end
    end

    // Tag/target/jump arrays: plain write-enabled storage.
    always_ff @(posedge clk) begin
        if (btb_alloc) begin
            tag_mem[upd_idx] <= upd_tag;
            jmp_mem[upd_idx] <= upd_jump;
        end
        if (tgt_write) begin
            target_mem[upd_idx] <= update_target;
        end
    end

    // Saturating mispredict statistics counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_reg <= '0;
        end else if (update_valid && update_mispredict && (stat_reg != 32'hFFFF_FFFF)) begin
            stat_reg <= stat_reg + 32'd1;
        end
    end

    assign stat_mispredicts = stat_reg;

    // Lookup path
    logic fetch_hit;

    assign fetch_hit   = valid_reg[fetch_idx] & (tag_mem[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit & (jmp_mem[fetch_idx] | look_ctr[1]);
    assign pred_target = pred_taken ? target_mem[fetch_idx] : (fetch_pc + XLEN'(4));

endmodule
